// File: rtl/alu_seq_pkg.sv
// Shared opcode groups, m-select codes, FSM state type and latched-control payload for alu_seq.
package alu_seq_pkg;

  // sel[3:2] opcode groups
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] SHR   = 2'b10;
  localparam logic [1:0] SHL   = 2'b11;

  // sel[1:0] within ARITH: second addend m
  localparam logic [1:0] M_ZERO = 2'b00;
  localparam logic [1:0] M_B    = 2'b01;
  localparam logic [1:0] M_NB   = 2'b10;
  localparam logic [1:0] M_ONES = 2'b11;

  // sel[1:0] within LOGIC
  localparam logic [1:0] LG_AND = 2'b00;
  localparam logic [1:0] LG_OR  = 2'b01;
  localparam logic [1:0] LG_XOR = 2'b10;
  localparam logic [1:0] LG_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic       sin;
  } op_ctl_t;

  // Single bit of the arithmetic second addend for a given m-select
  function automatic logic m_bit(input logic [1:0] msel, input logic bv);
    logic r;
    case (msel)
      M_ZERO:  r = 1'b0;
      M_B:     r = bv;
      M_NB:    r = ~bv;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: arithmetic, logic and one-bit shifts using neighbour bits.
module alu_digit
  import alu_seq_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             nb_hi,
  input  logic             nb_lo,
  input  logic             ci,
  input  logic [3:0]       sel,
  output logic [DIGIT-1:0] r,
  output logic             co
);

  logic [DIGIT-1:0] m;
  logic [DIGIT:0]   sum;
  logic [DIGIT+1:0] ext;

  always_comb begin
    m = '0;
    case (sel[1:0])
      M_ZERO:  m = '0;
      M_B:     m = b;
      M_NB:    m = ~b;
      default: m = '1;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, m} + (DIGIT+1)'(ci);
  // Neighbour bits framing the digit so shifts are plain slices
  assign ext = {nb_hi, a, nb_lo};

  always_comb begin
    r  = '0;
    co = 1'b0;
    case (sel[3:2])
      ARITH: begin
        r  = sum[DIGIT-1:0];
        co = sum[DIGIT];
      end
      LOGIC: begin
        case (sel[1:0])
          LG_AND:  r = a & b;
          LG_OR:   r = a | b;
          LG_XOR:  r = a ^ b;
          default: r = ~a;
        endcase
      end
      SHR:     r = ext[DIGIT+1:2];
      default: r = ext[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Digit-serial ALU: processes WIDTH/DIGIT digits LSB-first, one per cycle, through a shared slice.
// Define ALU_SEQ_FLAGS_EN to compile in the {V, N, Z} flag registers; otherwise flags reads 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [2:0]       flags
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  if ((DIGIT == 0) || (WIDTH % DIGIT != 0)) begin : g_width_check
    $error("alu_seq: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_ctl_t          ctl_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_acc;
  logic [WIDTH-1:0] res_nx;
  logic             last;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] base_hi;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] r_dig;
  logic             nb_hi;
  logic             nb_lo;
  logic             dig_co;

  assign last    = (cnt == CNT_W'(N - 1));
  assign base    = IDX_W'(cnt) * IDX_W'(DIGIT);
  assign base_hi = base + IDX_W'(DIGIT);

  // Current digit and its neighbours, always taken from the latched operand; sin fills the ends
  assign a_dig = DIGIT'(a_q >> base);
  assign b_dig = DIGIT'(b_q >> base);
  assign nb_hi = 1'({ctl_q.sin, a_q} >> base_hi);
  assign nb_lo = 1'({a_q, ctl_q.sin} >> base);

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_dig),
    .b     (b_dig),
    .nb_hi (nb_hi),
    .nb_lo (nb_lo),
    .ci    (carry_q),
    .sel   (ctl_q.sel),
    .r     (r_dig),
    .co    (dig_co)
  );

  // Partial result with the current digit merged in
  always_comb begin
    res_nx = res_acc;
    res_nx = (res_acc & ~(WIDTH'({DIGIT{1'b1}}) << base)) | (WIDTH'(r_dig) << base);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0] flags_nx;
  logic       ovf_nx;

  // Signed overflow: operands agree in sign but the sum does not
  assign ovf_nx = (ctl_q.sel[3:2] == ARITH)
               && (a_q[WIDTH-1] == m_bit(ctl_q.sel[1:0], b_q[WIDTH-1]))
               && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
  assign flags_nx = {ovf_nx, res_nx[WIDTH-1], ~|res_nx};
`else
  assign flags = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      res_acc <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flags   <= 3'b000;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_RUN);
      done  <= (state_nx == ST_DONE);
      if (state != ST_RUN) begin
        if (start) begin
          a_q       <= a;
          b_q       <= b;
          ctl_q.sel <= sel;
          ctl_q.sin <= sin;
          carry_q   <= cin;
          cnt       <= '0;
          res_acc   <= '0;
        end
      end else begin
        res_acc <= res_nx;
        carry_q <= dig_co;
        cnt     <= cnt + CNT_W'(1);
        if (last) begin
          result <= res_nx;
          cout   <= dig_co;
`ifdef ALU_SEQ_FLAGS_EN
          flags  <= flags_nx;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32, DIGIT=4): results, carries, flags, latency, start-in-RUN and mid-RUN reset.
module tb_alu_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned LAT   = WIDTH / DIGIT + 1;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [2:0]       flags;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sel    (sel),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sin    (sin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_flags(input logic [2:0] f);
    return FLAGS_ON ? f : 3'b000;
  endfunction

  // Called #1 after an edge; steps until done is seen (bounded), counting cycles since the accept edge
  task automatic wait_done(input int first_cyc, output int cyc, output bit busy_ok);
    bit seen;
    cyc     = first_cyc;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc <= 20) begin
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  // Issues one op from IDLE/DONE, scrambles inputs after acceptance, checks latency and outputs
  task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic si, input logic [31:0] er, input logic ec, input logic [2:0] ef);
    int cyc;
    bit busy_ok;
    sel = s; a = av; b = bv; cin = ci; sin = si; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sel = ~s; a = ~av; b = ~bv; cin = ~ci; sin = ~si;
    wait_done(1, cyc, busy_ok);
    check_eq({tag, ".latency"}, 32'(cyc), 32'(LAT));
    check_eq({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
    check_eq({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_eq({tag, ".result"}, result, er);
    check_eq({tag, ".cout"}, 32'(cout), 32'(ec));
    check_eq({tag, ".flags"}, 32'(flags), 32'(exp_flags(ef)));
  endtask

  task automatic idle_check(input string tag, input logic [31:0] er);
    @(posedge clk); #1;
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".held"}, result, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  cyc;
    bit  busy_ok;
    bit  seen;
    rst_n = 1'b0; start = 1'b0; sel = 4'h0; a = '0; b = '0; cin = 1'b0; sin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.result", result, 32'h0);
    check_eq("rst.cout", 32'(cout), 32'd0);
    check_eq("rst.flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap",  4'b0001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 3'b001);
    idle_check("add_wrap", 32'h00000000);
    run_op("sub",       4'b0010, 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 3'b010);
    run_op("add_ovf",   4'b0001, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 3'b110);
    run_op("shr",       4'b1000, 32'h80000001, 32'h00000000, 1'b0, 1'b1, 32'hC0000000, 1'b0, 3'b010);
    run_op("shl",       4'b1100, 32'h80000001, 32'h00000000, 1'b0, 1'b0, 32'h00000002, 1'b0, 3'b000);
    run_op("not",       4'b0111, 32'h0F0F0F0F, 32'h12345678, 1'b0, 1'b0, 32'hF0F0F0F0, 1'b0, 3'b010);
    run_op("and",       4'b0100, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 32'h0F000F00, 1'b0, 3'b000);
    idle_check("and", 32'h0F000F00);
    run_op("or",        4'b0101, 32'h12340000, 32'h00005678, 1'b0, 1'b0, 32'h12345678, 1'b0, 3'b000);
    run_op("xor",       4'b0110, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 1'b0, 32'h55555555, 1'b0, 3'b000);
    run_op("dec",       4'b0011, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 3'b010);
    run_op("inc",       4'b0000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 3'b001);
    run_op("add_novf",  4'b0001, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 3'b101);
    run_op("shl_fill",  4'b1100, 32'h00000008, 32'h00000000, 1'b0, 1'b1, 32'h00000011, 1'b0, 3'b000);
    run_op("shr_cross", 4'b1000, 32'h00000010, 32'h00000000, 1'b0, 1'b0, 32'h00000008, 1'b0, 3'b000);
    run_op("xfer",      4'b0011, 32'h89ABCDEF, 32'h00000000, 1'b1, 1'b0, 32'h89ABCDEF, 1'b1, 3'b010);
    idle_check("xfer", 32'h89ABCDEF);

    // start pulsed in RUN cycle 3 must be ignored
    sel = 4'b0001; a = 32'h00000100; b = 32'h00000023; cin = 1'b0; sin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sel = 4'b0010; a = 32'hDEAD0000; b = 32'h00001111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, cyc, busy_ok);
    check_eq("ign.latency", 32'(cyc), 32'(LAT));
    check_eq("ign.result", result, 32'h00000123);
    idle_check("ign", 32'h00000123);

    // reset asserted in RUN cycle 4 aborts the op
    sel = 4'b0001; a = 32'h00000001; b = 32'h00000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.done", 32'(done), 32'd0);
    check_eq("abort.result", result, 32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check_eq("abort.no_done", 32'(seen), 32'd0);
    run_op("post_rst", 4'b0001, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
